// File: rtl/ps2_port.sv
// ps2_port: PS/2 keyboard receiver with scancode FIFO, sticky status flags and not-empty irq.
// Optional PS2_BREAK_FILTER_EN drops F0-prefixed break codes so only make codes are queued.
module ps2_port #(
  parameter int FIFO_AW = 2,
  parameter int TIMEOUT = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  input  logic       RD_Data,
  input  logic       WR_Stat,
  output logic [7:0] data_out,
  output logic [7:0] status_out,
  output logic       irq
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [FIFO_AW:0] DEPTH = (FIFO_AW + 1)'(1 << FIFO_AW);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state_q, state_d;
  logic [2:0] sclk_q;
  logic [1:0] sdat_q;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic par_q, par_d, push_q, push_d;
  logic [TW-1:0] timer_q, timer_d;
  logic fall, dat, tout, accept, perr_set, ferr_set;
  logic [7:0] mem_q [1 << FIFO_AW];
  logic [FIFO_AW-1:0] rd_q, wr_q;
  logic [FIFO_AW:0] cnt_q, cnt_d;
  logic ovf_q, perr_q, ferr_q, full, do_push, do_pop, ovf_set;
`ifdef PS2_BREAK_FILTER_EN
  logic brk_q, brk_d;
`endif
  // sclk_q[2] holds the previous synchronised clock for edge detection
  assign fall = sclk_q[2] & ~sclk_q[1];
  assign dat = sdat_q[1];
  assign tout = state_q != IDLE && !fall && timer_q == TW'(TIMEOUT - 1);
  always_comb begin
    state_d = state_q;
    bitcnt_d = bitcnt_q;
    shreg_d = shreg_q;
    par_d = par_q;
    accept = 1'b0;
    perr_set = 1'b0;
    ferr_set = 1'b0;
    timer_d = (state_q == IDLE || fall || tout) ? '0 : timer_q + 1'b1;
    if (tout) begin
      state_d = IDLE;
      ferr_set = 1'b1;
    end else if (fall) begin
      case (state_q)
        IDLE: begin
          state_d = dat ? IDLE : DATA;
          bitcnt_d = 3'd0;
        end
        DATA: begin
          shreg_d = {dat, shreg_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          state_d = bitcnt_q == 3'd7 ? PARITY : DATA;
        end
        PARITY: begin
          par_d = dat;
          state_d = STOP;
        end
        default: begin
          state_d = IDLE;
          perr_set = ~^{shreg_q, par_q};
          ferr_set = ~dat;
          accept = dat & ^{shreg_q, par_q};
        end
      endcase
    end
`ifdef PS2_BREAK_FILTER_EN
    brk_d = tout ? 1'b0 : accept ? (!brk_q && shreg_q == 8'hF0) : brk_q;
    push_d = accept && !brk_q && shreg_q != 8'hF0;
`else
    push_d = accept;
`endif
  end
  assign full = cnt_q == DEPTH;
  assign irq = cnt_q != '0;
  assign do_pop = RD_Data && irq;
  assign do_push = push_q && (!full || do_pop);
  assign ovf_set = push_q && full && !RD_Data;
  assign cnt_d = (do_push && !do_pop) ? cnt_q + 1'b1 : (do_pop && !do_push) ? cnt_q - 1'b1 : cnt_q;
  assign data_out = irq ? mem_q[rd_q] : 8'h00;
  assign status_out = {3'(cnt_q), ferr_q, perr_q, ovf_q, full, irq};
  always_ff @(posedge clk) begin
    if (!rst) begin
      sclk_q <= '1;
      sdat_q <= '1;
      state_q <= IDLE;
      bitcnt_q <= '0;
      shreg_q <= '0;
      par_q <= 1'b0;
      timer_q <= '0;
      push_q <= 1'b0;
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      sclk_q <= {sclk_q[1:0], ps2_clk};
      sdat_q <= {sdat_q[0], ps2_dat};
      state_q <= state_d;
      bitcnt_q <= bitcnt_d;
      shreg_q <= shreg_d;
      par_q <= par_d;
      timer_q <= timer_d;
      push_q <= push_d;
      rd_q <= do_pop ? rd_q + 1'b1 : rd_q;
      wr_q <= do_push ? wr_q + 1'b1 : wr_q;
      cnt_q <= cnt_d;
      ovf_q <= ovf_set | (ovf_q & ~WR_Stat);
      perr_q <= perr_set | (perr_q & ~WR_Stat);
      ferr_q <= ferr_set | (ferr_q & ~WR_Stat);
    end
  end
`ifdef PS2_BREAK_FILTER_EN
  always_ff @(posedge clk) brk_q <= !rst ? 1'b0 : brk_d;
`endif
  always_ff @(posedge clk) if (do_push) mem_q[wr_q] <= shreg_q;
endmodule

// File: tb/tb_ps2_port.sv
// tb_ps2_port: directed + randomized frames against a queue-based model of the scancode port.
module tb_ps2_port;
  localparam int TO = 300;
  localparam int H = 10;
  logic clk = 1'b0, rst = 1'b0, ps2_clk = 1'b1, ps2_dat = 1'b1, RD_Data = 1'b0, WR_Stat = 1'b0;
  logic [7:0] data_out, status_out;
  logic irq;
  int tests = 0, fails = 0;
  logic [7:0] q[$];
  bit m_ovf = 0, m_perr = 0, m_ferr = 0, m_brk = 0;
  logic [7:0] nb;
  ps2_port #(.FIFO_AW(2), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat), .RD_Data(RD_Data),
    .WR_Stat(WR_Stat), .data_out(data_out), .status_out(status_out), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  function automatic logic [7:0] mstat();
    return {3'(q.size()), m_ferr, m_perr, m_ovf, q.size() == 4, q.size() != 0};
  endfunction
  task automatic chk(input string tag);
    logic [7:0] ed;
    ed = q.size() != 0 ? q[0] : 8'h00;
    tests += 3;
    assert (status_out === mstat()) else begin fails++; $error("FAIL %s status_out got %h expected %h", tag, status_out, mstat()); end
    assert (data_out === ed) else begin fails++; $error("FAIL %s data_out got %h expected %h", tag, data_out, ed); end
    assert (irq === (q.size() != 0)) else begin fails++; $error("FAIL %s irq got %b expected %b", tag, irq, q.size() != 0); end
  endtask
  task automatic chk_stat(input string tag, input logic [7:0] exp);
    tests++;
    assert (status_out === exp) else begin fails++; $error("FAIL %s status_out got %h expected %h", tag, status_out, exp); end
  endtask
  task automatic frame(input logic [7:0] b, input bit badpar, input bit stop, input int nbits);
    logic [10:0] bits;
    bits = {stop, ~(^b) ^ badpar, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = bits[i];
      cyc(H);
      ps2_clk = 1'b0;
      if (i < nbits - 1) begin
        cyc(H);
        ps2_clk = 1'b1;
      end
    end
  endtask
  task automatic fin();
    cyc(H);
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    cyc(H);
  endtask
  function automatic void accept(input logic [7:0] b);
`ifdef PS2_BREAK_FILTER_EN
    if (m_brk) begin m_brk = 0; return; end
    if (b == 8'hF0) begin m_brk = 1; return; end
`endif
    if (q.size() == 4) m_ovf = 1; else q.push_back(b);
  endfunction
  task automatic send(input logic [7:0] b, input bit badpar, input bit stop);
    frame(b, badpar, stop, 11);
    fin();
    if (badpar) m_perr = 1;
    if (!stop) m_ferr = 1;
    if (!badpar && stop) accept(b);
  endtask
  task automatic pop();
    RD_Data = 1'b1;
    cyc(1);
    RD_Data = 1'b0;
    if (q.size() != 0) q.delete(0);
  endtask
  task automatic clr();
    WR_Stat = 1'b1;
    cyc(1);
    WR_Stat = 1'b0;
    {m_ovf, m_perr, m_ferr} = 3'b000;
  endtask
  initial begin
    cyc(3);
    rst = 1'b1;
    cyc(1);
    chk("reset");
    frame(8'h1C, 0, 1, 11);
    cyc(3);
    tests++;
    assert (irq === 1'b0) else begin fails++; $error("FAIL latency_early irq got %b expected 0", irq); end
    cyc(1);
    q.push_back(8'h1C);
    chk("rx_1c");
    chk_stat("rx_1c_stat", 8'h21);
    fin();
    pop();
    chk("pop_1c");
    send(8'h1C, 1, 1);
    chk("perr");
    chk_stat("perr_stat", 8'h08);
    clr();
    chk("perr_clr");
    foreach (q[i]) q.delete(i);
    send(8'h15, 0, 1); send(8'h1D, 0, 1); send(8'h24, 0, 1); send(8'h2D, 0, 1); send(8'h2C, 0, 1);
    chk("fill");
    chk_stat("fill_stat", 8'h87);
    for (int i = 0; i < 4; i++) begin pop(); chk("drain"); end
    clr();
    for (int i = 0; i < 4; i++) send(8'($urandom_range(8'h7F, 1)), 0, 1);
    chk("full4");
    nb = 8'h5B;
    frame(nb, 0, 1, 11);
    cyc(3);
    RD_Data = 1'b1;
    cyc(1);
    RD_Data = 1'b0;
    q.delete(0);
    q.push_back(nb);
    fin();
    chk("full_pushpop");
    for (int i = 0; i < 4; i++) begin pop(); chk("pushpop_drain"); end
    frame(8'h5A, 0, 1, 5);
    cyc(TO + 5);
    m_ferr = 1;
    m_brk = 0;
    chk("timeout");
    chk_stat("timeout_stat", 8'h10);
    fin();
    send(8'h1C, 0, 1);
    chk("after_timeout");
    pop();
    clr();
    chk("after_timeout_clr");
    send(8'h33, 0, 1);
    frame(8'hA5, 0, 1, 6);
    cyc(H);
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    rst = 1'b0;
    cyc(2);
    rst = 1'b1;
    q.delete();
    {m_ovf, m_perr, m_ferr, m_brk} = 4'b0000;
    chk("rst_mid");
    send(8'h1C, 0, 1);
    chk("rst_then_1c");
    chk_stat("rst_then_1c_stat", 8'h21);
    pop();
`ifdef PS2_BREAK_FILTER_EN
    send(8'hF0, 0, 1); send(8'h1C, 0, 1); send(8'h1C, 0, 1);
    chk("break_filter");
    chk_stat("break_filter_stat", 8'h21);
    pop();
`endif
    for (int i = 0; i < 30; i++) begin
      send(8'($urandom), $urandom_range(5) == 0, $urandom_range(7) != 0);
      chk("rand_rx");
      if ($urandom_range(2) == 0) begin pop(); chk("rand_pop"); end
      if ($urandom_range(4) == 0) begin clr(); chk("rand_clr"); end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ps2_port.md
Name: ps2_port

Overview:
- PS/2 keyboard receive port feeding the PicoBlaze input mux: scancode data on port 3 (ps2_data), status on port 13 (ps2_status).
- Synchronises the external PS/2 clock and data lines and deserialises 11-bit frames.
- Buffers valid scancodes in a small FIFO.
- Exposes a data byte, a status byte and a not-empty interrupt request to the processor side.

Parameters:
- FIFO_AW, 2, FIFO address width; depth = 2^FIFO_AW; legal range 1..2.
- TIMEOUT, 20000, clk cycles allowed between PS/2 falling edges inside a frame (200 us at 100 MHz) before the frame is aborted.

Ports:
- clk  input  1  system clock, 100 MHz
- rst  input  1  reset, synchronous, active-low
- ps2_clk  input  1  raw PS/2 clock from connector, asynchronous
- ps2_dat  input  1  raw PS/2 data from connector, asynchronous
- RD_Data  input  1  one-cycle pop strobe; decoded read_strobe for port 3
- WR_Stat  input  1  one-cycle strobe; decoded write_strobe for port 13; clears sticky flags
- data_out  output  8  FIFO head scancode; 8'h00 when empty
- status_out  output  8  [0] not empty, [1] full, [2] overflow, [3] parity error, [4] frame error, [7:5] FIFO count
- irq  output  1  high while FIFO not empty

Behaviour:
- Synchroniser: ps2_clk and ps2_dat each pass through 2 flops.
  - Fall = sync_clk 1 on the previous cycle and 0 on the current cycle.
  - ps2_dat is sampled only on fall.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall with data=0 (start bit), go to DATA, bitcnt=0, timer cleared. On fall with data=1, stay in IDLE and discard.
  - DATA: on each fall, shift data into shreg LSB-first. After the 8th bit, go to PARITY.
  - PARITY: on fall, latch the parity bit, go to STOP.
  - STOP: on fall, return to IDLE. Accept the frame only if stop=1 and the 9 bits (data+parity) have odd parity.
  - Parity mismatch: discard, set sticky perr.
  - Stop=0: discard, set sticky ferr.
- Timer: counts clk cycles in any non-IDLE state and clears on every fall. Reaching TIMEOUT forces IDLE, discards the partial frame and sets ferr.
- Push: an accepted frame pushes shreg into the FIFO one cycle after the stop-bit fall.
- FIFO:
  - Registered memory, rd_ptr/wr_ptr of FIFO_AW bits that wrap modulo depth, count of FIFO_AW+1 bits.
  - data_out = mem[rd_ptr] combinationally when count>0, else 8'h00.
  - Pop: RD_Data with count>0 advances rd_ptr at the next edge. RD_Data when empty is ignored; no flag.
  - Push when full without a simultaneous pop: byte dropped, sticky ovf set, FIFO unchanged.
  - Push and pop in the same cycle: both performed, count unchanged. This holds when full, and when empty (empty: push only, pop ignored).
- status_out[7:5] = count zero-extended to 3 bits; full = (count == depth).
- Sticky flags ovf/perr/ferr: set by their events, cleared by WR_Stat at the next edge; a set event in the same cycle as WR_Stat wins.
- irq = (count != 0), registered with count; no extra latency.
- Reset (rst=0 at an edge), also mid-frame:
  - FSM to IDLE; shreg, bitcnt, timer, pointers, count and flags to 0.
  - Synchroniser flops to 1 (bus idle).
  - Outputs: data_out=8'h00, status_out=8'h00, irq=0.
- Latency: stop-bit fall (synchronised) to irq high = 2 clk.

Optional Feature:
- PS2_BREAK_FILTER_EN defined:
  - An accepted 8'hF0 is not pushed; a break_pend flag is set instead.
  - The next accepted byte is also discarded and break_pend is cleared.
  - 8'hE0 is pushed normally.
  - break_pend is cleared by reset and by a timeout; a frame error does not clear it.
  - Only make codes reach the processor.
- Not defined: every accepted byte, including F0, is pushed; no break_pend logic exists.

Test Plan:
- Send frame 0x1C with parity 0, stop 1 → 2 clk after the stop fall: data_out=0x1C, status_out=0x21, irq=1; RD_Data → status_out=0x00, irq=0.
- Send 0x1C with parity bit 1 → nothing pushed, status_out=0x08; WR_Stat → status_out=0x00.
- Send 5 frames 0x15,0x1D,0x24,0x2D,0x2C with no pops (depth 4) → status_out=0x87; pops return 0x15,0x1D,0x24,0x2D in order.
- With FIFO full, push on the same cycle as RD_Data → count stays 4, ovf stays 0, tail = new byte.
- Stop after 4 data bits, wait TIMEOUT+1 cycles → FSM in IDLE, status_out=0x10; a following clean 0x1C frame is received correctly.
- Assert rst mid-frame after 5 bits, then send 0x1C → only 0x1C in the FIFO. With PS2_BREAK_FILTER_EN, send F0,1C,1C → only one 0x1C queued.
